// File: rtl/fv_dup_scheduler.sv
// fv_dup_scheduler: issue sequencer between the fetch and execute trackers of
// the FV duplicate-checking core. It turns the free solver choices (dup,
// dup-sync, bubble) into a single-issue-per-cycle schedule. It also tracks how
// many duplicates are in flight, so that a sync marker is only sent once EX has drained.
module fv_dup_scheduler #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4,
    parameter int MAX_BUBBLES     = 3,
    parameter int SYNC_TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_instr_valid,
    input  logic             if_stall,
    input  logic             if_kill,
    input  logic             ex_queue_full,
    input  logic             no_uncommitted_instr,
    input  logic             attempt_dup,
    input  logic             attempt_dup_sync,
    input  logic             insert_bubble,
    input  logic             commit_dup,
    input  logic [CNT_W-1:0] killed_dups,
    output logic             issue_orig,
    output logic             issue_dup,
    output logic             issue_dup_sync,
    output logic             issue_bubble,
    output logic             consume,
    output logic [CNT_W-1:0] outstanding_dups,
    output logic [1:0]       sched_state,
    output logic             sched_error
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DUP       = 2'd1;
    localparam logic [1:0] ST_SYNC_WAIT = 2'd2;

    localparam int BUB_W  = $clog2(MAX_BUBBLES + 1);
    localparam int SYNC_W = $clog2(SYNC_TIMEOUT + 1);
    // Two bits of headroom: one for the sign, one so cur+1 never wraps.
    localparam int CALC_W = CNT_W + 2;

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  outstanding_next_s;
    logic [BUB_W-1:0]  bubble_cnt_r;
    logic [BUB_W-1:0]  bubble_cnt_next_s;
    logic [SYNC_W-1:0] sync_cnt_r;
    logic [SYNC_W-1:0] sync_cnt_next_s;
    logic              sched_error_r;

    logic              block_s;
    logic              active_s;
    logic              sync_go_s;
    logic              issue_orig_s;
    logic              issue_dup_s;
    logic              issue_dup_sync_s;
    logic              issue_bubble_s;
    logic              consume_s;
    logic [CALC_W-1:0] cnt_calc_s;
    logic              cnt_under_s;
    logic              cnt_over_s;
    logic              sync_timeout_s;

    assign block_s  = if_stall | ex_queue_full;
    // Issue decisions are made only outside reset, kill and back-pressure.
    assign active_s = ~reset & ~if_kill & ~block_s;

    // Output decode: at most one issue per cycle, from registered state and live inputs.
    always_comb begin
        issue_orig_s     = 1'b0;
        issue_dup_s      = 1'b0;
        issue_dup_sync_s = 1'b0;
        issue_bubble_s   = 1'b0;
        consume_s        = 1'b0;
        sync_go_s        = 1'b0;
        if (active_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (insert_bubble && (bubble_cnt_r < BUB_W'(MAX_BUBBLES))) begin
                        issue_bubble_s = 1'b1;
                    end else if (if_instr_valid && attempt_dup_sync) begin
                        sync_go_s = 1'b1;
                    end else if (if_instr_valid) begin
                        issue_orig_s = 1'b1;
                        // Hold the fetch head when a duplicate copy will follow.
                        if (attempt_dup && (outstanding_r < CNT_W'(MAX_OUTSTANDING))) begin
                            consume_s = 1'b0;
                        end else begin
                            consume_s = 1'b1;
                        end
                    end else begin
                        issue_orig_s = 1'b0;
                    end
                end
                ST_DUP: begin
                    issue_dup_s = 1'b1;
                    consume_s   = 1'b1;
                end
                ST_SYNC_WAIT: begin
                    if (no_uncommitted_instr && (outstanding_r == {CNT_W{1'b0}})) begin
                        issue_dup_sync_s = 1'b1;
                    end else begin
                        issue_dup_sync_s = 1'b0;
                    end
                end
                default: begin
                    issue_orig_s = 1'b0;
                end
            endcase
        end else begin
            issue_orig_s = 1'b0;
        end
    end

    // Next-state decode; kill returns to IDLE from any state.
    always_comb begin
        state_next_s = state_r;
        if (reset || if_kill) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sync_go_s) begin
                        state_next_s = ST_SYNC_WAIT;
                    end else if (issue_orig_s && !consume_s) begin
                        state_next_s = ST_DUP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DUP: begin
                    if (issue_dup_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DUP;
                    end
                end
                ST_SYNC_WAIT: begin
                    if (issue_dup_sync_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_SYNC_WAIT;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Outstanding-count arithmetic with signed headroom, clamping and error flags.
    always_comb begin
        cnt_calc_s = {2'b00, outstanding_r} + CALC_W'(issue_dup_s)
                   - CALC_W'(commit_dup) - {2'b00, killed_dups};
        cnt_under_s = cnt_calc_s[CALC_W-1];
        cnt_over_s  = ~cnt_calc_s[CALC_W-1] && (cnt_calc_s > CALC_W'(MAX_OUTSTANDING));
        if (cnt_under_s) begin
            outstanding_next_s = {CNT_W{1'b0}};
        end else if (cnt_over_s) begin
            outstanding_next_s = CNT_W'(MAX_OUTSTANDING);
        end else begin
            outstanding_next_s = cnt_calc_s[CNT_W-1:0];
        end
    end

    // Bubble run length and sync-wait age; both saturate at their limits.
    always_comb begin
        bubble_cnt_next_s = bubble_cnt_r;
        sync_cnt_next_s   = sync_cnt_r;
        sync_timeout_s    = 1'b0;
        if (if_kill) begin
            bubble_cnt_next_s = {BUB_W{1'b0}};
            sync_cnt_next_s   = {SYNC_W{1'b0}};
        end else begin
            if (block_s) begin
                bubble_cnt_next_s = bubble_cnt_r;
            end else if (issue_bubble_s) begin
                bubble_cnt_next_s = bubble_cnt_r + BUB_W'(1);
            end else begin
                bubble_cnt_next_s = {BUB_W{1'b0}};
            end
            if (state_r != ST_SYNC_WAIT || issue_dup_sync_s) begin
                sync_cnt_next_s = {SYNC_W{1'b0}};
            end else if (sync_cnt_r < SYNC_W'(SYNC_TIMEOUT)) begin
                sync_cnt_next_s = sync_cnt_r + SYNC_W'(1);
            end else begin
                sync_cnt_next_s = sync_cnt_r;
            end
            sync_timeout_s = (state_r == ST_SYNC_WAIT) &&
                             (sync_cnt_next_s == SYNC_W'(SYNC_TIMEOUT));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_r <= {CNT_W{1'b0}};
            bubble_cnt_r  <= {BUB_W{1'b0}};
            sync_cnt_r    <= {SYNC_W{1'b0}};
            sched_error_r <= 1'b0;
        end else begin
            outstanding_r <= outstanding_next_s;
            bubble_cnt_r  <= bubble_cnt_next_s;
            sync_cnt_r    <= sync_cnt_next_s;
            sched_error_r <= sched_error_r | cnt_under_s | cnt_over_s | sync_timeout_s;
        end
    end

    assign issue_orig       = issue_orig_s;
    assign issue_dup        = issue_dup_s;
    assign issue_dup_sync   = issue_dup_sync_s;
    assign issue_bubble     = issue_bubble_s;
    assign consume          = consume_s;
    assign outstanding_dups = outstanding_r;
    assign sched_state      = state_r;
    assign sched_error      = sched_error_r;

endmodule

// File: tb/tb_fv_dup_scheduler.sv
// Bench for fv_dup_scheduler: one record per clock cycle holding that cycle's
// inputs and the outputs expected during it, replayed through a scoreboard queue.
module tb_fv_dup_scheduler;

    logic       clk = 1'b0;
    logic       reset, if_instr_valid, if_stall, if_kill, ex_queue_full;
    logic       no_uncommitted_instr, attempt_dup, attempt_dup_sync, insert_bubble, commit_dup;
    logic [3:0] killed_dups;
    logic       issue_orig, issue_dup, issue_dup_sync, issue_bubble, consume;
    logic [3:0] outstanding_dups;
    logic [1:0] sched_state;
    logic       sched_error;

    always #5 clk = ~clk;

    fv_dup_scheduler dut (
        .clk(clk), .reset(reset), .if_instr_valid(if_instr_valid), .if_stall(if_stall),
        .if_kill(if_kill), .ex_queue_full(ex_queue_full),
        .no_uncommitted_instr(no_uncommitted_instr), .attempt_dup(attempt_dup),
        .attempt_dup_sync(attempt_dup_sync), .insert_bubble(insert_bubble),
        .commit_dup(commit_dup), .killed_dups(killed_dups), .issue_orig(issue_orig),
        .issue_dup(issue_dup), .issue_dup_sync(issue_dup_sync), .issue_bubble(issue_bubble),
        .consume(consume), .outstanding_dups(outstanding_dups), .sched_state(sched_state),
        .sched_error(sched_error)
    );

    // Input bit masks: {reset, valid, stall, kill, full, no_uncommitted, dup, sync, bubble, commit}
    localparam logic [9:0] R  = 10'h200, V = 10'h100, ST = 10'h080, K = 10'h040, FU = 10'h020;
    localparam logic [9:0] N  = 10'h010, D = 10'h008, S  = 10'h004, B = 10'h002, C  = 10'h001;
    localparam logic [9:0] Z  = 10'h000;
    // Issue vectors: {orig, dup, dup_sync, bubble, consume}
    localparam logic [4:0] I_NONE = 5'b00000, I_ORIG = 5'b10000, I_OC = 5'b10001;
    localparam logic [4:0] I_DC   = 5'b01001, I_SYNC = 5'b00100, I_BUB = 5'b00010;

    typedef struct {
        logic [9:0] in;
        logic [3:0] killed;
        logic [4:0] iss;
        logic [3:0] outs;
        logic [1:0] st;
        logic       err;
        logic       chk_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_idx  = 0;

    function automatic vec_t mk(input logic [9:0] in, input logic [3:0] killed,
                                input logic [4:0] iss, input logic [3:0] outs,
                                input logic [1:0] st, input logic err, input logic chk_err);
        vec_t v;
        v.in = in; v.killed = killed; v.iss = iss; v.outs = outs;
        v.st = st; v.err = err; v.chk_err = chk_err;
        return v;
    endfunction

    // Drive one cycle's inputs, queue its expectation, then compare mid-cycle.
    task automatic step(input vec_t v);
        vec_t       e;
        logic [4:0] act_iss;
        @(posedge clk);
        #1;
        {reset, if_instr_valid, if_stall, if_kill, ex_queue_full,
         no_uncommitted_instr, attempt_dup, attempt_dup_sync, insert_bubble, commit_dup} = v.in;
        killed_dups = v.killed;
        sb_q.push_back(v);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL row %0d scoreboard empty", row_idx);
        end else begin
            e = sb_q.pop_front();
            act_iss = {issue_orig, issue_dup, issue_dup_sync, issue_bubble, consume};
            checks++;
            if (act_iss !== e.iss) begin
                failures++;
                $display("FAIL row %0d issue got=%b want=%b", row_idx, act_iss, e.iss);
            end
            checks++;
            if (outstanding_dups !== e.outs) begin
                failures++;
                $display("FAIL row %0d outstanding got=%0d want=%0d", row_idx, outstanding_dups, e.outs);
            end
            checks++;
            if (sched_state !== e.st) begin
                failures++;
                $display("FAIL row %0d state got=%0d want=%0d", row_idx, sched_state, e.st);
            end
            if (e.chk_err) begin
                checks++;
                if (sched_error !== e.err) begin
                    failures++;
                    $display("FAIL row %0d sched_error got=%b want=%b", row_idx, sched_error, e.err);
                end
            end
        end
        row_idx++;
    endtask

    initial begin
        {reset, if_instr_valid, if_stall, if_kill, ex_queue_full,
         no_uncommitted_instr, attempt_dup, attempt_dup_sync, insert_bubble, commit_dup} = R;
        killed_dups = 4'd0;
        repeat (2) @(posedge clk);

        // Reset holds all issue outputs low even with requests present.
        tbl.push_back(mk(R|V|B, 4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Dup pair, then kill in the DUP cycle, then EX reports the kill.
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V,     4'd0, I_DC,   4'd0, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|K,   4'd0, I_NONE, 4'd1, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd1, I_NONE, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Dup pair retired by commit_dup.
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V,     4'd0, I_DC,   4'd0, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(C,     4'd0, I_NONE, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Bubble cap: three bubbles, one masked cycle, bubbles resume.
        tbl.push_back(mk(V|B,   4'd0, I_BUB,  4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|B,   4'd0, I_BUB,  4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|B,   4'd0, I_BUB,  4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|B,   4'd0, I_OC,   4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|B,   4'd0, I_BUB,  4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Back-pressure blocks all issue.
        tbl.push_back(mk(V|ST,  4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|FU|D,4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Reset in the DUP cycle returns to IDLE with no issue.
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(R|V,   4'd0, I_NONE, 4'd0, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Sync with two duplicates outstanding.
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V,     4'd0, I_DC,   4'd0, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(V|D,   4'd0, I_ORIG, 4'd1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V,     4'd0, I_DC,   4'd1, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(V|S|N, 4'd0, I_NONE, 4'd2, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|N,   4'd0, I_NONE, 4'd2, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V|C,   4'd0, I_NONE, 4'd2, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V|C,   4'd0, I_NONE, 4'd1, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V,     4'd0, I_NONE, 4'd0, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V|N|ST,4'd0, I_NONE, 4'd0, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V|N,   4'd0, I_SYNC, 4'd0, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(V|N,   4'd0, I_OC,   4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        // Outstanding limit: eight pairs, then the ninth dup request is ignored.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(V|D, 4'd0, I_ORIG, 4'(i), 2'd0, 1'b0, 1'b1));
            tbl.push_back(mk(V,   4'd0, I_DC,   4'(i), 2'd1, 1'b0, 1'b1));
        end
        tbl.push_back(mk(V|D,   4'd0, I_OC,   4'd8, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd8, 2'd0, 1'b0, 1'b1));
        // Kill in SYNC_WAIT keeps the count; EX then kills all eight.
        tbl.push_back(mk(V|S,   4'd0, I_NONE, 4'd8, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(V|K,   4'd0, I_NONE, 4'd8, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd8, I_NONE, 4'd8, 2'd0, 1'b0, 1'b1));
        // Underflow sets a sticky error; only reset clears it.
        tbl.push_back(mk(C,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(R|V|B, 4'd0, I_NONE, 4'd0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(Z,     4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));

        foreach (tbl[i]) step(tbl[i]);

        // Sync timeout: EX never drains, error rises around the 64th wait cycle.
        step(mk(V|S, 4'd0, I_NONE, 4'd0, 2'd0, 1'b0, 1'b1));
        for (int k = 0; k < 70; k++) begin
            step(mk(V, 4'd0, I_NONE, 4'd0, 2'd2, (k >= 64) ? 1'b1 : 1'b0,
                    ((k <= 62) || (k >= 66)) ? 1'b1 : 1'b0));
        end
        // Reset out of SYNC_WAIT with the drain condition met: still no issue.
        step(mk(R|V|N, 4'd0, I_NONE, 4'd0, 2'd2, 1'b1, 1'b1));
        step(mk(V|N,   4'd0, I_OC,   4'd0, 2'd0, 1'b0, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
